// File: rtl/ili9341_bus_decoder.sv
// Receive side of the ILI9341 8080 write bus: decodes window/RAMWR/power commands into framebuffer writes.
// Define ILI9341_BUS_SYNC_EN to pass the bus through 2-flop synchronizers (asynchronous panel driver).
module ili9341_bus_decoder #(
    parameter int X_MAX = 319,
    parameter int Y_MAX = 239,
    parameter int AW    = 9
) (
    input  logic          clk_16MHz,
    input  logic          resetn,
    input  logic          lcd_nreset,
    input  logic          lcd_cmd_data,
    input  logic          lcd_write_edge,
    input  logic [7:0]    lcd_din,
    output logic          fb_we,
    output logic [AW-1:0] fb_x,
    output logic [AW-1:0] fb_y,
    output logic [15:0]   fb_pixel,
    output logic          display_on,
    output logic          sleep_out,
    output logic          frame_done,
    output logic          param_err
);

    logic       nreset_i;
    logic       cd_i;
    logic       we_i;
    logic [7:0] din_i;

`ifdef ILI9341_BUS_SYNC_EN
    logic [1:0] nrst_q;
    logic [1:0] cd_q;
    logic [1:0] we_q;
    logic [7:0] din_q1;
    logic [7:0] din_q2;

    always_ff @(posedge clk_16MHz) begin
        if (!resetn) begin
            nrst_q <= '0;
            cd_q   <= '0;
            we_q   <= '0;
            din_q1 <= '0;
            din_q2 <= '0;
        end else begin
            nrst_q <= {nrst_q[0], lcd_nreset};
            cd_q   <= {cd_q[0], lcd_cmd_data};
            we_q   <= {we_q[0], lcd_write_edge};
            din_q1 <= lcd_din;
            din_q2 <= din_q1;
        end
    end

    assign nreset_i = nrst_q[1];
    assign cd_i     = cd_q[1];
    assign we_i     = we_q[1];
    assign din_i    = din_q2;
`else
    assign nreset_i = lcd_nreset;
    assign cd_i     = lcd_cmd_data;
    assign we_i     = lcd_write_edge;
    assign din_i    = lcd_din;
`endif

    typedef enum logic [2:0] {IDLE, CASET, PASET, RAM_HI, RAM_LO, SKIP} state_t;

    state_t        state;
    logic          prev;
    logic [1:0]    pidx;
    logic [15:0]   s_sh;
    logic [7:0]    e_hi;
    logic [7:0]    hi;
    logic [AW-1:0] sc, ec, sp, ep;
    logic [AW-1:0] cx, cy;

    logic        stb;
    logic        hard_rst;
    logic        soft_rst;
    logic [15:0] e_full;
    logic        x_ok;
    logic        y_ok;

    assign stb      = we_i & ~prev;
    assign hard_rst = ~resetn | ~nreset_i;
    assign soft_rst = stb & ~cd_i & (din_i == 8'h01);
    assign e_full   = {e_hi, din_i};
    assign x_ok     = (s_sh <= e_full) && (e_full <= 16'(X_MAX));
    assign y_ok     = (s_sh <= e_full) && (e_full <= 16'(Y_MAX));

    always_ff @(posedge clk_16MHz) begin
        if (hard_rst || soft_rst) begin
            // Software reset keeps the edge detector so a held strobe is not seen twice.
            prev       <= hard_rst ? 1'b0 : we_i;
            state      <= IDLE;
            pidx       <= '0;
            s_sh       <= '0;
            e_hi       <= '0;
            hi         <= '0;
            sc         <= '0;
            ec         <= AW'(X_MAX);
            sp         <= '0;
            ep         <= AW'(Y_MAX);
            cx         <= '0;
            cy         <= '0;
            fb_we      <= 1'b0;
            fb_x       <= '0;
            fb_y       <= '0;
            fb_pixel   <= '0;
            display_on <= 1'b0;
            sleep_out  <= 1'b0;
            frame_done <= 1'b0;
            param_err  <= 1'b0;
        end else begin
            prev       <= we_i;
            fb_we      <= 1'b0;
            frame_done <= 1'b0;
            if (stb && !cd_i) begin
                case (din_i)
                    8'h2A: begin state <= CASET; pidx <= '0; end
                    8'h2B: begin state <= PASET; pidx <= '0; end
                    8'h2C: begin state <= RAM_HI; cx <= sc; cy <= sp; end
                    8'h28: begin display_on <= 1'b0; state <= IDLE; end
                    8'h29: begin display_on <= 1'b1; state <= IDLE; end
                    8'h10: begin sleep_out <= 1'b0; state <= IDLE; end
                    8'h11: begin sleep_out <= 1'b1; state <= IDLE; end
                    default: state <= SKIP;
                endcase
            end else if (stb) begin
                case (state)
                    CASET, PASET: begin
                        pidx <= pidx + 2'd1;
                        case (pidx)
                            2'd0: s_sh[15:8] <= din_i;
                            2'd1: s_sh[7:0]  <= din_i;
                            2'd2: e_hi       <= din_i;
                            default: begin
                                state <= SKIP;
                                if (state == CASET && x_ok) begin
                                    sc <= s_sh[AW-1:0];
                                    ec <= e_full[AW-1:0];
                                end else if (state == PASET && y_ok) begin
                                    sp <= s_sh[AW-1:0];
                                    ep <= e_full[AW-1:0];
                                end else begin
                                    param_err <= 1'b1;
                                end
                            end
                        endcase
                    end
                    RAM_HI: begin
                        hi    <= din_i;
                        state <= RAM_LO;
                    end
                    RAM_LO: begin
                        fb_we    <= 1'b1;
                        fb_pixel <= {hi, din_i};
                        fb_x     <= cx;
                        fb_y     <= cy;
                        state    <= RAM_HI;
                        if (cx != ec) begin
                            cx <= cx + 1'b1;
                        end else begin
                            cx <= sc;
                            if (cy != ep) begin
                                cy <= cy + 1'b1;
                            end else begin
                                cy         <= sp;
                                frame_done <= 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ili9341_bus_decoder.sv
// Bench for ili9341_bus_decoder: table-driven bus traffic with a write scoreboard, plus hand sequences.
module tb_ili9341_bus_decoder;

    localparam int AW = 9;
`ifdef ILI9341_BUS_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic          clk_16MHz = 1'b0;
    logic          resetn = 1'b0;
    logic          lcd_nreset = 1'b1;
    logic          lcd_cmd_data = 1'b0;
    logic          lcd_write_edge = 1'b0;
    logic [7:0]    lcd_din = 8'h00;
    logic          fb_we;
    logic [AW-1:0] fb_x;
    logic [AW-1:0] fb_y;
    logic [15:0]   fb_pixel;
    logic          display_on;
    logic          sleep_out;
    logic          frame_done;
    logic          param_err;

    ili9341_bus_decoder #(.X_MAX(319), .Y_MAX(239), .AW(AW)) dut (
        .clk_16MHz(clk_16MHz),
        .resetn(resetn),
        .lcd_nreset(lcd_nreset),
        .lcd_cmd_data(lcd_cmd_data),
        .lcd_write_edge(lcd_write_edge),
        .lcd_din(lcd_din),
        .fb_we(fb_we),
        .fb_x(fb_x),
        .fb_y(fb_y),
        .fb_pixel(fb_pixel),
        .display_on(display_on),
        .sleep_out(sleep_out),
        .frame_done(frame_done),
        .param_err(param_err)
    );

    always #31 clk_16MHz = ~clk_16MHz;

    typedef struct {
        bit          cd;
        logic [7:0]  b;
        bit          wr;
        int          x;
        int          y;
        logic [15:0] px;
        bit          fd;
    } vec_t;

    typedef struct {
        int          x;
        int          y;
        logic [15:0] px;
        bit          fd;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   pass_cnt = 0;
    int   total_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        total_cnt++;
        if (act === expv) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, expv);
    endtask

    function automatic void add(input bit cd, input logic [7:0] b, input bit wr = 0,
                                input int x = 0, input int y = 0,
                                input logic [15:0] px = 16'h0, input bit fd = 0);
        vecs.push_back('{cd, b, wr, x, y, px, fd});
    endfunction

    // One strobe: high one cycle, low one cycle (the fastest rate the decoder must take).
    task automatic send(input bit cd, input logic [7:0] b);
        @(posedge clk_16MHz); #1;
        lcd_cmd_data   = cd;
        lcd_din        = b;
        lcd_write_edge = 1'b1;
        @(posedge clk_16MHz); #1;
        lcd_write_edge = 1'b0;
    endtask

    task automatic pix(input int x, input int y, input logic [15:0] px, input bit fd);
        sb.push_back('{x, y, px, fd});
        send(1'b1, px[15:8]);
        send(1'b1, px[7:0]);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk_16MHz);
        #1;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_we"}, 32'(fb_we), 0);
        check({tag, "_x"}, 32'(fb_x), 0);
        check({tag, "_y"}, 32'(fb_y), 0);
        check({tag, "_pixel"}, 32'(fb_pixel), 0);
        check({tag, "_display_on"}, 32'(display_on), 0);
        check({tag, "_sleep_out"}, 32'(sleep_out), 0);
        check({tag, "_frame_done"}, 32'(frame_done), 0);
        check({tag, "_param_err"}, 32'(param_err), 0);
    endtask

    // Write monitor: every fb_we must match the oldest outstanding expectation.
    exp_t        mon_e;
    logic        mon_prev_we = 1'b0;
    logic [34:0] mon_act;
    logic [34:0] mon_exp;
    always @(negedge clk_16MHz) begin
        if (fb_we) begin
            total_cnt++;
            mon_act = {fb_x, fb_y, fb_pixel, frame_done};
            if (sb.size() == 0) begin
                $display("FAIL unexpected_write: got x=%0d y=%0d pixel=%h required no write", fb_x, fb_y, fb_pixel);
            end else begin
                mon_e   = sb.pop_front();
                mon_exp = {AW'(mon_e.x), AW'(mon_e.y), mon_e.px, mon_e.fd};
                if (mon_act === mon_exp) pass_cnt++;
                else $display("FAIL write: got x=%0d y=%0d pixel=%h fd=%0b required x=%0d y=%0d pixel=%h fd=%0b",
                              fb_x, fb_y, fb_pixel, frame_done, mon_e.x, mon_e.y, mon_e.px, mon_e.fd);
            end
            if (mon_prev_we) begin
                total_cnt++;
                $display("FAIL we_gap: got fb_we high two cycles running required single pulse");
            end
        end
        if (frame_done && !fb_we) begin
            total_cnt++;
            $display("FAIL frame_done_alone: got frame_done=1 with fb_we=0 required coincident");
        end
        mon_prev_we = fb_we;
    end

    initial begin
        idle(3);
        check_reset("rst");
        resetn = 1'b1;
        idle(3);

        // Init, full-width window, first pixels
        add(0, 8'h01); add(0, 8'h11);
        add(0, 8'h2A); add(1, 8'h00); add(1, 8'h00); add(1, 8'h01); add(1, 8'h3F);
        add(0, 8'h2B); add(1, 8'h00); add(1, 8'h00); add(1, 8'h00); add(1, 8'hEF);
        add(0, 8'h29); add(0, 8'h2C);
        add(1, 8'hF8); add(1, 8'h00, 1, 0, 0, 16'hF800, 0);
        add(1, 8'h07); add(1, 8'hE0, 1, 1, 0, 16'h07E0, 0);
        // 2x2 window with wrap and frame_done; stray data after CASET is ignored
        add(0, 8'h2A); add(1, 8'h00); add(1, 8'h0A); add(1, 8'h00); add(1, 8'h0B); add(1, 8'h55);
        add(0, 8'h2B); add(1, 8'h00); add(1, 8'h05); add(1, 8'h00); add(1, 8'h06);
        add(0, 8'h2C);
        add(1, 8'h11); add(1, 8'h11, 1, 10, 5, 16'h1111, 0);
        add(1, 8'h22); add(1, 8'h22, 1, 11, 5, 16'h2222, 0);
        add(1, 8'h33); add(1, 8'h33, 1, 10, 6, 16'h3333, 0);
        add(1, 8'h44); add(1, 8'h44, 1, 11, 6, 16'h4444, 1);
        add(1, 8'h55); add(1, 8'h55, 1, 10, 5, 16'h5555, 0);
        // SC > EC rejected: old window stays
        add(0, 8'h2A); add(1, 8'h00); add(1, 8'h14); add(1, 8'h00); add(1, 8'h0A);
        add(0, 8'h2C); add(1, 8'hAB); add(1, 8'hCD, 1, 10, 5, 16'hABCD, 0);
        // EC = 320 rejected
        add(0, 8'h2A); add(1, 8'h00); add(1, 8'h00); add(1, 8'h01); add(1, 8'h40);
        add(0, 8'h2C); add(1, 8'h01); add(1, 8'h02, 1, 10, 5, 16'h0102, 0);
        // Pending high byte aborted by a command
        add(0, 8'h2C); add(1, 8'h12);
        add(0, 8'h2A); add(1, 8'h00); add(1, 8'h02); add(1, 8'h00); add(1, 8'h03);
        add(0, 8'h2C);
        add(1, 8'h99); add(1, 8'h88, 1, 2, 5, 16'h9988, 0);
        add(1, 8'h77); add(1, 8'h66, 1, 3, 5, 16'h7766, 0);
        add(1, 8'h11); add(1, 8'h22, 1, 2, 6, 16'h1122, 0);
        // Unknown opcode: following data ignored
        add(0, 8'h00); add(1, 8'hAA); add(1, 8'hBB);

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].wr) sb.push_back('{vecs[i].x, vecs[i].y, vecs[i].px, vecs[i].fd});
            send(vecs[i].cd, vecs[i].b);
        end
        idle(5);
        check("display_on_set", 32'(display_on), 1);
        check("sleep_out_set", 32'(sleep_out), 1);
        check("param_err_sticky", 32'(param_err), 1);
        check("fb_x_hold", 32'(fb_x), 2);
        check("fb_pixel_hold", 32'(fb_pixel), 32'h1122);

        send(0, 8'h28);
        send(0, 8'h10);
        idle(5);
        check("display_on_clr", 32'(display_on), 0);
        check("sleep_out_clr", 32'(sleep_out), 0);

        // Window at the far corner, EC/EP exactly at the limits
        send(0, 8'h2A); send(1, 8'h01); send(1, 8'h3E); send(1, 8'h01); send(1, 8'h3F);
        send(0, 8'h2B); send(1, 8'h00); send(1, 8'hEE); send(1, 8'h00); send(1, 8'hEF);
        send(0, 8'h2C);
        pix(318, 238, 16'hC001, 0);
        pix(319, 238, 16'hC002, 0);
        pix(318, 239, 16'hC003, 0);
        pix(319, 239, 16'hC004, 1);

        // Write latency from the second strobe
        sb.push_back('{318, 238, 16'h5A3C, 0});
        send(1, 8'h5A);
        @(posedge clk_16MHz); #1;
        lcd_din = 8'h3C; lcd_cmd_data = 1'b1; lcd_write_edge = 1'b1;
        repeat (LAT) @(posedge clk_16MHz);
        #1;
        check("write_latency", 32'(fb_we), 1);
        lcd_write_edge = 1'b0;
        idle(4);

        // resetn mid-pixel
        send(0, 8'h2C);
        send(1, 8'h77);
        resetn = 1'b0;
        idle(2);
        check_reset("resetn");
        resetn = 1'b1;
        idle(3);
        send(1, 8'h66);
        send(1, 8'h55);

        send(0, 8'h2B); send(1, 8'h00); send(1, 8'h00); send(1, 8'h00); send(1, 8'hF0);
        idle(5);
        check("paset_ep240_rejected", 32'(param_err), 1);

        // Panel hardware reset
        send(0, 8'h29);
        idle(4);
        lcd_nreset = 1'b0;
        idle(4);
        check_reset("nreset");
        lcd_nreset = 1'b1;
        idle(4);

        // Software reset mid-pixel, then default window restored
        send(0, 8'h29);
        send(0, 8'h2C);
        send(1, 8'h44);
        send(0, 8'h01);
        idle(5);
        check_reset("swreset");
        send(1, 8'h33);
        send(1, 8'h22);
        send(0, 8'h2C);
        for (int i = 0; i < 321; i++) pix(i % 320, i / 320, 16'(i) ^ 16'hA5C3, 0);

        for (int t = 0; t < 20 && sb.size() != 0; t++) @(posedge clk_16MHz);
        idle(4);
        check("writes_outstanding", 32'(sb.size()), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
